// File: rtl/jelly_wishbone_width_bridge.sv
// jelly_wishbone_width_bridge: registered Wishbone data-width bridge between an upstream and a downstream port.
// Ports: clk; reset_n (async, active-low); endian (0 little / 1 big, sampled when a request is accepted);
//   s_wb_adr_i/dat_i/we_i/sel_i/stb_i upstream request, s_wb_dat_o/ack_o registered upstream response;
//   m_wb_adr_o/dat_o/we_o/sel_o/stb_o registered downstream request, m_wb_dat_i/ack_i downstream response.
module jelly_wishbone_width_bridge #(
    parameter int S_WB_DAT_SIZE  = 3,
    parameter int S_WB_ADR_WIDTH = 29,
    parameter int M_WB_DAT_SIZE  = 2,
    parameter int M_WB_ADR_WIDTH = S_WB_ADR_WIDTH + S_WB_DAT_SIZE - M_WB_DAT_SIZE,
    parameter int S_WB_DAT_WIDTH = 8 << S_WB_DAT_SIZE,
    parameter int S_WB_SEL_WIDTH = 1 << S_WB_DAT_SIZE,
    parameter int M_WB_DAT_WIDTH = 8 << M_WB_DAT_SIZE,
    parameter int M_WB_SEL_WIDTH = 1 << M_WB_DAT_SIZE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      endian,
    input  logic [S_WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [S_WB_DAT_WIDTH-1:0] s_wb_dat_i,
    input  logic                      s_wb_we_i,
    input  logic [S_WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                      s_wb_stb_i,
    output logic [S_WB_DAT_WIDTH-1:0] s_wb_dat_o,
    output logic                      s_wb_ack_o,
    output logic [M_WB_ADR_WIDTH-1:0] m_wb_adr_o,
    output logic [M_WB_DAT_WIDTH-1:0] m_wb_dat_o,
    output logic                      m_wb_we_o,
    output logic [M_WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                      m_wb_stb_o,
    input  logic [M_WB_DAT_WIDTH-1:0] m_wb_dat_i,
    input  logic                      m_wb_ack_i
);
    localparam int RATE = S_WB_DAT_SIZE > M_WB_DAT_SIZE ? S_WB_DAT_SIZE - M_WB_DAT_SIZE : M_WB_DAT_SIZE - S_WB_DAT_SIZE;
    localparam int N    = 1 << RATE;
    localparam int RW   = RATE > 0 ? RATE : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                    state_q, state_d;
    logic [S_WB_ADR_WIDTH-1:0] adr_q, adr_d;
    logic [S_WB_DAT_WIDTH-1:0] dat_q, dat_d, rdat_q, rdat_d;
    logic [S_WB_SEL_WIDTH-1:0] sel_q, sel_d;
    logic                      we_q, we_d, endian_q, endian_d;
    logic [RW-1:0]             beat_q, beat_d;
    logic [M_WB_ADR_WIDTH-1:0] m_adr_q, m_adr_d;
    logic [M_WB_DAT_WIDTH-1:0] m_dat_q, m_dat_d;
    logic [M_WB_SEL_WIDTH-1:0] m_sel_q, m_sel_d;
    logic                      m_we_q, m_we_d, m_stb_q, m_stb_d, s_ack_q, s_ack_d;

    // Beat lookup runs on the live request while idle and on the latched one while accessing,
    // so the first beat can be registered in the same edge that accepts the request.
    logic                      idle, advance, cur_we, cur_end, nxt_v;
    logic [S_WB_ADR_WIDTH-1:0] cur_adr;
    logic [S_WB_DAT_WIDTH-1:0] cur_dat, rcap;
    logic [S_WB_SEL_WIDTH-1:0] cur_sel;
    logic [RW:0]               start;
    logic [RW-1:0]             nxt_k;
    logic [M_WB_ADR_WIDTH-1:0] b_adr;
    logic [M_WB_DAT_WIDTH-1:0] b_dat;
    logic [M_WB_SEL_WIDTH-1:0] b_sel;

    assign idle    = state_q == IDLE;
    assign cur_adr = idle ? s_wb_adr_i : adr_q;
    assign cur_dat = idle ? s_wb_dat_i : dat_q;
    assign cur_sel = idle ? s_wb_sel_i : sel_q;
    assign cur_we  = idle ? s_wb_we_i  : we_q;
    assign cur_end = idle ? endian     : endian_q;
    assign start   = idle ? '0 : (RW+1)'(beat_q) + (RW+1)'(1);

    generate
        if (S_WB_DAT_SIZE > M_WB_DAT_SIZE) begin : g_narrow
            logic [RW-1:0] lane, rlane;
            always_comb begin
                nxt_v = 1'b0;
                nxt_k = '0;
                // Descending scan leaves the lowest issuable beat at or after start.
                for (int k = N - 1; k >= 0; k--) begin
                    if (k >= int'(start) && cur_sel[(k ^ (cur_end ? N - 1 : 0)) * M_WB_SEL_WIDTH +: M_WB_SEL_WIDTH] != '0) begin
                        nxt_v = 1'b1;
                        nxt_k = RW'(k);
                    end
                end
                lane  = nxt_k ^ {RW{cur_end}};
                b_adr = {cur_adr, nxt_k};
                b_dat = cur_dat[lane * M_WB_DAT_WIDTH +: M_WB_DAT_WIDTH];
                b_sel = cur_sel[lane * M_WB_SEL_WIDTH +: M_WB_SEL_WIDTH];
                rlane = beat_q ^ {RW{endian_q}};
                rcap  = rdat_q;
                rcap[rlane * M_WB_DAT_WIDTH +: M_WB_DAT_WIDTH] = m_wb_dat_i;
            end
        end else if (M_WB_DAT_SIZE > S_WB_DAT_SIZE) begin : g_wide
            logic [RW-1:0] lane;
            always_comb begin
                lane  = cur_adr[RW-1:0] ^ {RW{cur_end}};
                nxt_v = idle && cur_sel != '0;
                nxt_k = lane;
                b_adr = cur_adr[S_WB_ADR_WIDTH-1:RW];
                b_dat = {N{cur_dat}};
                b_sel = M_WB_SEL_WIDTH'(cur_sel) << (lane * S_WB_SEL_WIDTH);
                rcap  = m_wb_dat_i[beat_q * S_WB_DAT_WIDTH +: S_WB_DAT_WIDTH];
            end
        end else begin : g_equal
            always_comb begin
                nxt_v = idle;
                nxt_k = '0;
                b_adr = cur_adr;
                b_dat = cur_dat;
                b_sel = cur_sel;
                rcap  = m_wb_dat_i;
            end
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        we_d     = we_q;
        sel_d    = sel_q;
        endian_d = endian_q;
        beat_d   = beat_q;
        rdat_d   = rdat_q;
        m_adr_d  = m_adr_q;
        m_dat_d  = m_dat_q;
        m_sel_d  = m_sel_q;
        m_we_d   = m_we_q;
        m_stb_d  = m_stb_q;
        s_ack_d  = 1'b0;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_wb_stb_i) begin
                    adr_d    = s_wb_adr_i;
                    dat_d    = s_wb_dat_i;
                    we_d     = s_wb_we_i;
                    sel_d    = s_wb_sel_i;
                    endian_d = endian;
                    rdat_d   = '0;
                    advance  = 1'b1;
                end
            end
            ACCESS: begin
                if (m_wb_ack_i) begin
                    rdat_d  = we_q ? rdat_q : rcap;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // s_ack is registered on entry to RESPOND so it is high exactly during that state.
        if (advance) begin
            state_d = nxt_v ? ACCESS : RESPOND;
            s_ack_d = !nxt_v;
            m_stb_d = nxt_v;
            m_we_d  = nxt_v & cur_we;
            if (nxt_v) begin
                beat_d  = nxt_k;
                m_adr_d = b_adr;
                m_dat_d = b_dat;
                m_sel_d = b_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            endian_q <= 1'b0;
            beat_q   <= '0;
            rdat_q   <= '0;
            m_adr_q  <= '0;
            m_dat_q  <= '0;
            m_sel_q  <= '0;
            m_we_q   <= 1'b0;
            m_stb_q  <= 1'b0;
            s_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            endian_q <= endian_d;
            beat_q   <= beat_d;
            rdat_q   <= rdat_d;
            m_adr_q  <= m_adr_d;
            m_dat_q  <= m_dat_d;
            m_sel_q  <= m_sel_d;
            m_we_q   <= m_we_d;
            m_stb_q  <= m_stb_d;
            s_ack_q  <= s_ack_d;
        end
    end

    assign s_wb_dat_o = rdat_q;
    assign s_wb_ack_o = s_ack_q;
    assign m_wb_adr_o = m_adr_q;
    assign m_wb_dat_o = m_dat_q;
    assign m_wb_sel_o = m_sel_q;
    assign m_wb_we_o  = m_we_q;
    assign m_wb_stb_o = m_stb_q;
endmodule
